// File: rtl/e603_mrom_scan.sv
// e603_mrom_scan -- walks a block of words on a read-only ICB port and adds
// them up.
//
// A scan issues one read at a time, starting at base_addr and stepping by one
// word. Each good response is added into sum, modulo 2^DW. An error response
// stops the scan and sets err. The end of a scan is marked by a one-cycle
// done pulse.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   start               one-cycle request, accepted only when idle
//   base_addr           byte start address; bits [1:0] are ignored
//   word_cnt            number of words to read
//   busy, done          scan in flight / one-cycle completion pulse
//   sum, err            checksum and error flag, held until the next start
//   icb_cmd_*           command channel (reads only)
//   icb_rsp_*           response channel
module e603_mrom_scan #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] word_cnt,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic          err,
  output logic          icb_cmd_valid,
  input  logic          icb_cmd_ready,
  output logic [AW-1:0] icb_cmd_addr,
  output logic          icb_cmd_read,
  input  logic          icb_rsp_valid,
  output logic          icb_rsp_ready,
  input  logic          icb_rsp_err,
  input  logic [DW-1:0] icb_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-3:0] base_w;
  logic [CW-1:0] cnt, idx, idx_inc;
  logic          accept, cmd_hs, rsp_hs, last;
  logic          unused_ok;

  // The byte offset bits of the base address carry no information.
  assign unused_ok = ^base_addr[1:0];

  assign accept  = (state == IDLE) && start;
  assign cmd_hs  = icb_cmd_valid && icb_cmd_ready;
  // In CMD a response only counts when it arrives together with the command
  // handshake. With at most one read outstanding, any earlier response is
  // stray and is ignored.
  assign rsp_hs  = icb_rsp_valid &&
                   (((state == CMD) && icb_cmd_ready) || (state == WAIT));
  assign idx_inc = idx + CW'(1);
  assign last    = (idx_inc == cnt);

  assign busy          = (state == CMD) || (state == WAIT);
  assign done          = (state == DONE);
  assign icb_cmd_valid = (state == CMD);
  assign icb_rsp_ready = busy;
  assign icb_cmd_read  = 1'b1;
  // The address is built in word units, so stepping past the top of the
  // address space wraps back to word 0.
  assign icb_cmd_addr  = {base_w + (AW-2)'(idx), 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (word_cnt == '0) ? DONE : CMD;
      CMD:
        if (cmd_hs) begin
          if (icb_rsp_valid) state_nxt = (icb_rsp_err || last) ? DONE : CMD;
          else               state_nxt = WAIT;
        end
      WAIT: if (icb_rsp_valid) state_nxt = (icb_rsp_err || last) ? DONE : CMD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_w <= '0;
      cnt    <= '0;
      idx    <= '0;
      sum    <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      base_w <= base_addr[AW-1:2];
      cnt    <= word_cnt;
      idx    <= '0;
      sum    <= '0;
      err    <= 1'b0;
    end else if (rsp_hs) begin
      if (icb_rsp_err) begin
        err <= 1'b1;
      end else begin
        sum <= sum + icb_rsp_rdata;
        idx <= idx_inc;
      end
    end
  end

endmodule

// File: tb/tb_e603_mrom_scan.sv
module tb_e603_mrom_scan;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_cnt;
  logic          busy, done, err;
  logic [DW-1:0] sum;
  logic          icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [DW-1:0] icb_rsp_rdata;

  int checks = 0;
  int failures = 0;

  // responder control
  logic          same_mode, inject;
  int            err_at, cmd_no;
  logic          d_cmd_ready, d_rsp_valid;
  logic [DW-1:0] d_rdata;
  logic [DW-1:0] rom [0:1023];

  // scoreboard
  logic [AW-1:0] exp_addr_q [$];
  logic [DW:0]   exp_res_q  [$];   // {err, sum}

  always #5 clk = ~clk;

  e603_mrom_scan #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .sum(sum), .err(err),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata)
  );

  // same-cycle ROM responder, or directly driven delayed responder
  always_comb begin
    if (same_mode) begin
      icb_cmd_ready = icb_rsp_ready;
      icb_rsp_valid = icb_cmd_valid;
      icb_rsp_rdata = rom[icb_cmd_addr[AW-1:2]];
      icb_rsp_err   = inject && (cmd_no == err_at);
    end else begin
      icb_cmd_ready = d_cmd_ready;
      icb_rsp_valid = d_rsp_valid;
      icb_rsp_rdata = d_rdata;
      icb_rsp_err   = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (start) cmd_no <= 0;
    else if (icb_cmd_valid && icb_cmd_ready) cmd_no <= cmd_no + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard pops, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && icb_cmd_valid && icb_cmd_ready) begin
      if (exp_addr_q.size() == 0) chk("cmd_extra", {63'd0, icb_cmd_valid}, 64'd0);
      else chk("cmd_addr", {52'd0, icb_cmd_addr}, {52'd0, exp_addr_q.pop_front()});
      chk("cmd_read", {63'd0, icb_cmd_read}, 64'd1);
    end
    if (rst_n && done) begin
      if (exp_res_q.size() == 0) chk("done_extra", {63'd0, done}, 64'd0);
      else chk("done_result", {31'd0, err, sum}, {31'd0, exp_res_q.pop_front()});
      chk("done_busy", {63'd0, busy}, 64'd0);
    end
  end

  // reference: expected addresses and final {err,sum}; eat<0 means no error
  task automatic push_scan(input int base, input int cnt, input int eat, output logic [DW-1:0] s);
    logic e;
    int   a;
    e = 1'b0;
    s = '0;
    for (int i = 0; i < cnt; i++) begin
      a = ((base >> 2) + i) % 1024;
      exp_addr_q.push_back(AW'(a << 2));
      if (i == eat) begin
        e = 1'b1;
        break;
      end
      s = s + rom[a];
    end
    exp_res_q.push_back({e, s});
  endtask

  task automatic start_scan(input logic [AW-1:0] b, input logic [CW-1:0] c);
    start = 1'b1; base_addr = b; word_cnt = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat counts cycles with the start cycle as cycle 0
  task automatic wait_done(input string tag, input int exp_lat, input int lat0);
    int lat;
    lat = lat0;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_sum"}, {32'd0, sum}, 64'd0);
    chk({tag, "_cval"}, {63'd0, icb_cmd_valid}, 64'd0);
    chk({tag, "_rrdy"}, {63'd0, icb_rsp_ready}, 64'd0);
    chk({tag, "_addr"}, {52'd0, icb_cmd_addr}, 64'd0);
  endtask

  // delayed responder: ready low 2 cycles (stray rsp_valid meanwhile),
  // response 3 cycles after acceptance
  task automatic delayed_word(input logic [DW-1:0] data, input logic [DW-1:0] sum_before);
    logic [AW-1:0] a0;
    int t;
    t = 0;
    while (!icb_cmd_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("dly_cval", {63'd0, icb_cmd_valid}, 64'd1);
    a0 = icb_cmd_addr;
    d_rsp_valid = 1'b1; d_rdata = 32'hDEAD_0000;
    repeat (2) begin
      @(posedge clk); #1;
      chk("dly_hold_valid", {63'd0, icb_cmd_valid}, 64'd1);
      chk("dly_hold_addr", {52'd0, icb_cmd_addr}, {52'd0, a0});
      chk("dly_stray_sum", {32'd0, sum}, {32'd0, sum_before});
    end
    d_rsp_valid = 1'b0; d_cmd_ready = 1'b1;
    @(posedge clk); #1;
    d_cmd_ready = 1'b0;
    repeat (2) begin
      chk("dly_wait_cval", {63'd0, icb_cmd_valid}, 64'd0);
      chk("dly_wait_rrdy", {63'd0, icb_rsp_ready}, 64'd1);
      chk("dly_wait_busy", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
    end
    chk("dly_wait_cval", {63'd0, icb_cmd_valid}, 64'd0);
    d_rsp_valid = 1'b1; d_rdata = data;
    @(posedge clk); #1;
    d_rsp_valid = 1'b0;
    chk("dly_sum", {32'd0, sum}, {32'd0, sum_before + data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] s;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
    same_mode = 1'b1; inject = 1'b0; err_at = 0;
    d_cmd_ready = 1'b0; d_rsp_valid = 1'b0; d_rdata = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'(i * 3 + 7);
    rom[4] = 1; rom[5] = 2; rom[6] = 3; rom[7] = 4;
    rom[1023] = 32'hFFFF_FFFF; rom[0] = 32'h2;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic same-cycle scan
    push_scan(12'h010, 4, -1, s);
    start_scan(12'h010, 11'd4);
    chk("basic_busy", {63'd0, busy}, 64'd1);
    wait_done("basic", 5, 1);
    chk("basic_sum", {32'd0, sum}, 64'd10);
    chk("basic_err", {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    chk("basic_idle_done", {63'd0, done}, 64'd0);
    chk("basic_hold_sum", {32'd0, sum}, 64'd10);

    // zero-length scan
    push_scan(12'h100, 0, -1, s);
    start_scan(12'h100, 11'd0);
    chk("zero_busy", {63'd0, busy}, 64'd0);
    wait_done("zero", 1, 1);
    chk("zero_sum", {32'd0, sum}, 64'd0);
    @(posedge clk); #1;

    // delayed responder
    same_mode = 1'b0;
    push_scan(12'h040, 2, -1, s);
    rom[16] = 32'h1111_1111; rom[17] = 32'h2222_0000;
    exp_res_q.delete();
    exp_res_q.push_back({1'b0, 32'h3333_1111});
    start_scan(12'h040, 11'd2);
    delayed_word(32'h1111_1111, 32'h0);
    delayed_word(32'h2222_0000, 32'h1111_1111);
    chk("dly_done", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    same_mode = 1'b1;

    // error on 2nd response
    inject = 1'b1; err_at = 1;
    push_scan(12'h100, 4, 1, s);
    start_scan(12'h100, 11'd4);
    wait_done("errscan", 3, 1);
    chk("errscan_err", {63'd0, err}, 64'd1);
    chk("errscan_sum", {32'd0, sum}, {32'd0, rom[64]});
    inject = 1'b0;
    @(posedge clk); #1;
    chk("errscan_hold_err", {63'd0, err}, 64'd1);

    // address wrap
    push_scan(12'hFFC, 2, -1, s);
    start_scan(12'hFFC, 11'd2);
    wait_done("wrap", 3, 1);
    chk("wrap_sum", {32'd0, sum}, 64'd1);
    chk("wrap_err", {63'd0, err}, 64'd0);
    @(posedge clk); #1;

    // restart while busy is ignored
    push_scan(12'h020, 3, -1, s);
    start_scan(12'h020, 11'd3);
    start = 1'b1; base_addr = 12'h200; word_cnt = 11'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("restart", 4, 2);
    chk("restart_sum", {32'd0, sum}, {32'd0, s});
    @(posedge clk); #1;

    // reset mid-scan
    push_scan(12'h010, 4, -1, s);
    start_scan(12'h010, 11'd4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_res_q.delete();
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    chk_zero("midrst_hold");
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("postrst_done", {63'd0, done}, 64'd0);
      chk("postrst_busy", {63'd0, busy}, 64'd0);
    end

    // recovery scan
    push_scan(12'h010, 4, -1, s);
    start_scan(12'h010, 11'd4);
    wait_done("recover", 5, 1);
    chk("recover_sum", {32'd0, sum}, 64'd10);
    repeat (2) @(posedge clk);
    #1;
    chk("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
    chk("res_q_drained", 64'(exp_res_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
